mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Memory-stage load/store unit: consumer of the EX/MEM pipeline register outputs (address, store data,
//  funct3, write/read enables). Converts one pipeline memory op into a req/gnt/rvalid transaction on the
//  data bus, generates byte enables and lane-aligned write data, and sign/zero-extends load data for WB.
//  Stalls the pipeline (o_stall) until the transaction completes.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles spent in REQ+WAIT before abort; 0 disables the timeout counter
//  CNT_W        8    width of timeout counter; must satisfy TIMEOUT_CYC < 2**CNT_W
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst         in   1   reset, asynchronous, active-high
//  i_req_M       in   1   MEM-stage instruction is a memory op (held stable while o_stall=1)
//  i_mem_wren_M  in   1   1=store, 0=load (store wins if both decoded)
//  i_funct3_M    in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_addr_M      in   32  byte address (ALU result)
//  i_st_data_M   in   32  store data (rs2), LSB-justified
//  o_stall       out  1   hold IF/ID/EX/MEM registers
//  o_ld_data     out  32  extended load data, valid with o_ld_valid
//  o_ld_valid    out  1   1-cycle pulse, load result ready for MEM/WB
//  o_lsu_err     out  1   1-cycle pulse: illegal funct3, misalign (if enabled) or timeout
//  o_bus_req     out  1   bus request, held until i_bus_gnt
//  o_bus_we      out  1   bus write
//  o_bus_addr    out  32  word-aligned bus address ({addr[31:2],2'b00})
//  o_bus_be      out  4   byte enables
//  o_bus_wdata   out  32  lane-replicated write data
//  i_bus_gnt     in   1   request accepted this cycle
//  i_bus_rvalid  in   1   read data valid this cycle
//  i_bus_rdata   in   32  read data word
// BEHAVIOUR
//  - Reset: state=IDLE, timeout counter=0; all outputs 0 (o_stall = i_req_M combinationally, see below).
//    Async reset mid-transaction drops o_bus_req immediately; no completion or error pulse is produced.
//  - o_stall = i_req_M & (state != DONE). Pipeline advances on the DONE-cycle edge.
//  - FSM: IDLE -> REQ when i_req_M & legal access; IDLE -> ERR when illegal; REQ -> DONE on gnt (store)
//    or WAIT on gnt (load); WAIT -> DONE on i_bus_rvalid; ERR -> DONE; DONE -> IDLE unconditionally.
//  - Request fields (addr, be, wdata, we, funct3) are registered on IDLE exit and held constant in REQ.
//  - o_bus_req=1 only in REQ. i_bus_rvalid outside WAIT is ignored.
//  - Min latency: store 3 cycles (IDLE,REQ+gnt,DONE); load 4 cycles with rvalid the cycle after gnt.
//  - BE: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
//    wdata: B = {4{st[7:0]}}, H = {2{st[15:0]}}, W = st.
//  - Load extract: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend.
//    rdata captured in WAIT on rvalid; o_ld_data/o_ld_valid driven in DONE only, o_ld_data=0 otherwise.
//  - Illegal funct3 (011,110,111; 100/101 on stores): no bus activity; o_lsu_err pulses in DONE.
//  - Timeout: counter increments each cycle in REQ/WAIT, clears in IDLE; at TIMEOUT_CYC -> DONE with
//    o_lsu_err=1, o_ld_valid=0, o_bus_req deasserted. Bus responses arriving later are ignored.
//  - Back-to-back ops: new i_req_M sampled only in IDLE, so one idle cycle separates transactions.
// CONFIGURATION
//  MEM_LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 takes the ERR path
//    (no bus request, o_lsu_err pulse in DONE).
//  Not defined: no alignment check; H uses addr[1] only, W ignores addr[1:0]; access proceeds normally.
// TESTING
//  SW addr=0x100 data=0xDEADBEEF, gnt first REQ cycle -> be=1111, wdata=0xDEADBEEF, stall 2 cycles
//  SB addr=0x103 data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, o_bus_addr=0x100
//  LB addr=0x102, rdata=0x00800000 -> o_ld_data=0xFFFFFF80; LBU same -> 0x00000080, o_ld_valid 1 cycle
//  LH addr=0x102, gnt delayed 3 cycles, rdata=0x8001xxxx -> o_ld_data=0xFFFF8001, req held 4 cycles
//  TIMEOUT_CYC=4, load with no rvalid -> o_lsu_err pulse, o_ld_valid=0, stall released after 4 cycles
//  LW addr=0x101 -> with MEM_LSU_MISALIGN_TRAP_EN: no req, err pulse; without: o_bus_addr=0x100 read
//  i_rst pulsed during WAIT -> o_bus_req/o_ld_valid/o_lsu_err 0 immediately, FSM in IDLE next cycle

Source files
------------

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : Memory-stage load/store unit that turns one pipeline memory op
//            into a req/gnt/rvalid bus transaction and holds the pipeline
//            stalled until that transaction completes. Build option:
//            MEM_LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_M,
    input  logic        i_mem_wren_M,
    input  logic [2:0]  i_funct3_M,
    input  logic [31:0] i_addr_M,
    input  logic [31:0] i_st_data_M,
    output logic        o_stall,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_lsu_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_ERR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int unsigned    c_TO_LAST_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [CNT_W-1:0] c_TO_LAST = c_TO_LAST_I[CNT_W-1:0];
    localparam logic           c_TO_EN     = (TIMEOUT_CYC != 0);

    state_t           state_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [3:0]       be_q;
    logic [2:0]       funct3_q;
    logic             we_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_f3_ok;
    logic        w_misalign;
    logic        w_legal;
    logic        w_timeout;
    logic        w_done;
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;
    logic [31:0] w_ext;

    // Decode of the incoming op: lane enables, replicated store data, legality.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (i_funct3_M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_addr_M[1:0];
                w_wdata = {4{i_st_data_M[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {i_addr_M[1], 1'b0};
                w_wdata = {2{i_st_data_M[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = i_st_data_M;
            end
            default: ;
        endcase

        case (i_funct3_M)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = ~i_mem_wren_M;
            default:                w_f3_ok = 1'b0;
        endcase

        w_misalign = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        w_misalign = ((i_funct3_M[1:0] == 2'b01) && i_addr_M[0]) ||
                     ((i_funct3_M[1:0] == 2'b10) && (i_addr_M[1:0] != 2'b00));
`endif
        w_legal = w_f3_ok & ~w_misalign;
    end

    assign w_timeout = c_TO_EN && (cnt_q == c_TO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            be_q     <= 4'b0000;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (i_req_M) begin
                        addr_q   <= i_addr_M;
                        be_q     <= w_be;
                        wdata_q  <= w_wdata;
                        we_q     <= i_mem_wren_M;
                        funct3_q <= i_funct3_M;
                        err_q    <= ~w_legal;
                        state_q  <= w_legal ? S_REQ : S_ERR;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A store grant finishes the op outright; a load grant only
                    // counts if the timeout budget is not exhausted this cycle.
                    if (i_bus_gnt && we_q) begin
                        state_q <= S_DONE;
                    end else if (w_timeout) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else if (i_bus_gnt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (i_bus_rvalid) begin
                        rdata_q <= i_bus_rdata;
                        state_q <= S_DONE;
                    end else if (w_timeout) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_ERR:   state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    w_lbyte = rdata_q[7:0];
            2'd1:    w_lbyte = rdata_q[15:8];
            2'd2:    w_lbyte = rdata_q[23:16];
            default: w_lbyte = rdata_q[31:24];
        endcase
        w_lhalf = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q)
            3'b000:  w_ext = {{24{w_lbyte[7]}}, w_lbyte};
            3'b001:  w_ext = {{16{w_lhalf[15]}}, w_lhalf};
            3'b100:  w_ext = {24'h0, w_lbyte};
            3'b101:  w_ext = {16'h0, w_lhalf};
            default: w_ext = rdata_q;
        endcase
    end

    assign w_done      = (state_q == S_DONE);
    assign o_stall     = i_req_M & ~w_done;
    assign o_ld_valid  = w_done & ~err_q & ~we_q;
    assign o_lsu_err   = w_done & err_q;
    assign o_ld_data   = o_ld_valid ? w_ext : 32'h0;
    assign o_bus_req   = (state_q == S_REQ);
    assign o_bus_we    = we_q;
    assign o_bus_addr  = {addr_q[31:2], 2'b00};
    assign o_bus_be    = be_q;
    assign o_bus_wdata = wdata_q;

endmodule

`default_nettype wire
